identifier_regs: RTL and testbench
==================================

// Module: identifier_regs
// PURPOSE
//  Parametrised successor of the read-only identifier: full AXI4-Lite slave exposing a magic word,
//  version, build ID, uptime counter, name string of configurable length and a R/W scratch register.
//  Sits on the control interconnect of every IpLibrary design. Software uses it to discover and
//  sanity-check the bitstream; the scratch register doubles as a bus-integrity test.
// PARAMETERS
//  NAME           "TEST"     ASCII name; packed as 32*NAME_WORDS-bit vector, right-justified, zero-padded at MSB
//  NAME_WORDS     4          number of 32-bit name words (1..16)
//  MAJOR_VERSION  1          8-bit major version
//  MINOR_VERSION  0          8-bit minor version
//  PATCH_VERSION  0          16-bit patch version
//  BUILD_ID       32'h0      build identifier (e.g. timestamp) set by the build flow
//  ADDR_WIDTH     8          byte address width of araddr/awaddr (>= 7)
// PORTS
//  aclk           in   1           clock; all logic rising-edge
//  areset         in   1           synchronous, active-high reset
//  ctrl_awvalid   in   1           write address valid
//  ctrl_awready   out  1           write address ready
//  ctrl_awaddr    in   ADDR_WIDTH  write byte address
//  ctrl_wvalid    in   1           write data valid
//  ctrl_wready    out  1           write data ready
//  ctrl_wdata     in   32          write data
//  ctrl_wstrb     in   4           byte enables
//  ctrl_bvalid    out  1           write response valid
//  ctrl_bready    in   1           write response ready
//  ctrl_bresp     out  2           00 OKAY, 10 SLVERR
//  ctrl_arvalid   in   1           read address valid
//  ctrl_arready   out  1           read address ready
//  ctrl_araddr    in   ADDR_WIDTH  read byte address
//  ctrl_rvalid    out  1           read data valid
//  ctrl_rready    in   1           read data ready
//  ctrl_rdata     out  32          read data
//  ctrl_rresp     out  2           00 OKAY, 10 SLVERR
// BEHAVIOUR
//  Map (byte addr, addr[1:0] ignored): 0x00 MAGIC=32'h49444E54 RO | 0x04 VERSION={MAJ[7:0],MIN[7:0],PATCH[15:0]} RO
//   0x08 BUILD_ID RO | 0x0C UPTIME RO | 0x10 SCRATCH RW | 0x14 NAME_WORDS RO
//   0x40+4k NAME word k (k<NAME_WORDS) RO = NAME bits [32*(NAME_WORDS-k)-1 -: 32]; first chars in lowest k.
//   Any other address: read rdata=0 rresp=10; any write except SCRATCH: no effect, bresp=10.
//  Reset: arready=1, awready=wready=0, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00, SCRATCH=0, UPTIME=0.
//  Read FSM R_IDLE/R_RESP: R_IDLE arready=1; arvalid -> latch data/resp, go R_RESP (rvalid 1 cycle after AR hs).
//   R_RESP: arready=0, rvalid=1, rdata/rresp stable until rready; rready -> R_IDLE. Back-to-back: 2 cycles/read.
//  Write FSM W_IDLE/W_RESP: accept only when awvalid&wvalid both high in W_IDLE; awready=wready pulse 1 cycle
//   together (combinational on both valids, W_IDLE only); SCRATCH updated per wstrb byte on that edge.
//   Next cycle bvalid=1 held until bready; no new write accepted while bvalid=1.
//  UPTIME: 32-bit free-running cycle counter from reset, wraps 0xFFFFFFFF->0; read value = counter at AR hs.
//  Same-cycle read and write of SCRATCH: read returns pre-write value.
//  Read and write channels independent; both may complete in the same cycle.
//  areset mid-transaction: pending rvalid/bvalid dropped next edge, FSMs to IDLE, no response issued.
// TESTING
//  Reset, read 0x00,0x04 (MAJ=2,MIN=3,PATCH=4) -> 32'h49444E54, 32'h02030004, rresp=00, rvalid 1 cycle after AR.
//  NAME="TEST",NAME_WORDS=4: read 0x40,0x4C -> 0, 32'h54455354; read 0x50 -> rdata=0 rresp=10.
//  Write 0x10 data 32'hDEADBEEF wstrb=4'b0101, read -> 32'h00AD00EF; write 0x04 -> bresp=10, VERSION unchanged.
//  Hold rready=0 10 cycles after AR: rvalid/rdata stable, arready=0; awvalid alone (no wvalid) -> no awready.
//  Two UPTIME reads 100 cycles apart -> difference 100 (mod 2^32) incl. forced wrap near 0xFFFFFFFF.
//  Assert areset while rvalid=1 and bvalid=1 -> both 0 next cycle, SCRATCH reads 0 afterwards.

Source files
------------

// File: rtl/identifier_regs.sv
// AXI4-Lite identifier block: magic word, version, build ID, uptime, name string and a scratch register.
// Software reads it to discover the bitstream; the scratch register is a bus-integrity target.
module identifier_regs #(
    parameter                NAME          = "TEST",
    parameter int            NAME_WORDS    = 4,
    parameter logic [7:0]    MAJOR_VERSION = 8'd1,
    parameter logic [7:0]    MINOR_VERSION = 8'd0,
    parameter logic [15:0]   PATCH_VERSION = 16'd0,
    parameter logic [31:0]   BUILD_ID      = 32'h0,
    parameter int            ADDR_WIDTH    = 8,
    parameter logic [31:0]   UPTIME_RESET  = 32'h0
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  ctrl_awvalid,
    output logic                  ctrl_awready,
    input  logic [ADDR_WIDTH-1:0] ctrl_awaddr,
    input  logic                  ctrl_wvalid,
    output logic                  ctrl_wready,
    input  logic [31:0]           ctrl_wdata,
    input  logic [3:0]            ctrl_wstrb,
    output logic                  ctrl_bvalid,
    input  logic                  ctrl_bready,
    output logic [1:0]            ctrl_bresp,
    input  logic                  ctrl_arvalid,
    output logic                  ctrl_arready,
    input  logic [ADDR_WIDTH-1:0] ctrl_araddr,
    output logic                  ctrl_rvalid,
    input  logic                  ctrl_rready,
    output logic [31:0]           ctrl_rdata,
    output logic [1:0]            ctrl_rresp
);

    localparam int                   NAME_BITS   = 32 * NAME_WORDS;
    localparam logic [NAME_BITS-1:0] NAME_VEC    = NAME_BITS'(NAME);
    localparam logic [31:0]          MAGIC       = 32'h49444E54;
    localparam logic [31:0]          VERSION     = {MAJOR_VERSION, MINOR_VERSION, PATCH_VERSION};
    localparam logic [4:0]           NAME_CNT    = 5'(NAME_WORDS);
    localparam int                   EXT_W       = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;
    localparam logic [1:0]           RESP_OKAY   = 2'b00;
    localparam logic [1:0]           RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_RESP} rstate_t;
    typedef enum logic {W_IDLE, W_RESP} wstate_t;

    rstate_t     r_state_q;
    wstate_t     w_state_q;
    logic        arready_q, rvalid_q, bvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q, bresp_q;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] uptime_q, uptime_d;

    logic [EXT_W-1:0] ar_ext, aw_ext;
    logic [31:0]      rd_data_d;
    logic [1:0]       rd_resp_d;
    logic             w_fire, aw_is_scratch;
    logic [31:0]      name_word [16];
    logic             unused_addr_bits;

    assign ar_ext           = EXT_W'(ctrl_araddr);
    assign aw_ext           = EXT_W'(ctrl_awaddr);
    assign unused_addr_bits = ^{ar_ext[1:0], aw_ext[1:0]};

    // Name word k carries the leftmost characters first, so word 0 sits at the MSB end of NAME_VEC.
    for (genvar g = 0; g < 16; g++) begin : g_name
        if (g < NAME_WORDS) begin : g_used
            assign name_word[g] = NAME_VEC[32*(NAME_WORDS-g)-1 -: 32];
        end else begin : g_pad
            assign name_word[g] = '0;
        end
    end

    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_OKAY;
        if (ar_ext[EXT_W-1:5] == '0) begin
            case (ar_ext[4:2])
                3'd0:    rd_data_d = MAGIC;
                3'd1:    rd_data_d = VERSION;
                3'd2:    rd_data_d = BUILD_ID;
                3'd3:    rd_data_d = uptime_q;
                3'd4:    rd_data_d = scratch_q;
                3'd5:    rd_data_d = 32'(NAME_WORDS);
                default: rd_resp_d = RESP_SLVERR;
            endcase
        end else if (ar_ext[EXT_W-1:7] == '0 && ar_ext[6] && ({1'b0, ar_ext[5:2]} < NAME_CNT)) begin
            rd_data_d = name_word[ar_ext[5:2]];
        end else begin
            rd_resp_d = RESP_SLVERR;
        end
    end

    // Both channels must be valid together; the ready pulse is the acceptance itself.
    assign w_fire        = (w_state_q == W_IDLE) && ctrl_awvalid && ctrl_wvalid;
    assign aw_is_scratch = (aw_ext[EXT_W-1:5] == '0) && (aw_ext[4:2] == 3'd4);

    always_comb begin
        scratch_d = scratch_q;
        if (w_fire && aw_is_scratch) begin
            for (int b = 0; b < 4; b++) begin
                if (ctrl_wstrb[b]) begin
                    scratch_d[8*b +: 8] = ctrl_wdata[8*b +: 8];
                end
            end
        end
    end

    assign uptime_d = uptime_q + 32'd1;

    always_ff @(posedge aclk) begin
        if (areset) begin
            scratch_q <= '0;
            uptime_q  <= UPTIME_RESET;
        end else begin
            scratch_q <= scratch_d;
            uptime_q  <= uptime_d;
        end
    end

    // Read data is captured at the AR handshake, so a concurrent scratch write is not visible yet.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ctrl_arvalid) begin
                        r_state_q <= R_RESP;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_data_d;
                        rresp_q   <= rd_resp_d;
                    end
                end
                R_RESP: begin
                    if (ctrl_rready) begin
                        r_state_q <= R_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (w_fire) begin
                        w_state_q <= W_RESP;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= aw_is_scratch ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (ctrl_bready) begin
                        w_state_q <= W_IDLE;
                        bvalid_q  <= 1'b0;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign ctrl_arready = arready_q;
    assign ctrl_rvalid  = rvalid_q;
    assign ctrl_rdata   = rdata_q;
    assign ctrl_rresp   = rresp_q;
    assign ctrl_awready = w_fire;
    assign ctrl_wready  = w_fire;
    assign ctrl_bvalid  = bvalid_q;
    assign ctrl_bresp   = bresp_q;

endmodule

// File: tb/tb_identifier_regs.sv
// Directed bench for identifier_regs: register map, scratch byte strobes, flow control, uptime and reset.
module tb_identifier_regs;

    logic        aclk, areset;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [7:0]  awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] UP_RST = 32'hFFFF_FFC0;

    identifier_regs #(
        .NAME          ("TEST"),
        .NAME_WORDS    (4),
        .MAJOR_VERSION (8'd2),
        .MINOR_VERSION (8'd3),
        .PATCH_VERSION (16'd4),
        .BUILD_ID      (32'h1234_5678),
        .ADDR_WIDTH    (8),
        .UPTIME_RESET  (UP_RST)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .ctrl_awvalid (awvalid),
        .ctrl_awready (awready),
        .ctrl_awaddr  (awaddr),
        .ctrl_wvalid  (wvalid),
        .ctrl_wready  (wready),
        .ctrl_wdata   (wdata),
        .ctrl_wstrb   (wstrb),
        .ctrl_bvalid  (bvalid),
        .ctrl_bready  (bready),
        .ctrl_bresp   (bresp),
        .ctrl_arvalid (arvalid),
        .ctrl_arready (arready),
        .ctrl_araddr  (araddr),
        .ctrl_rvalid  (rvalid),
        .ctrl_rready  (rready),
        .ctrl_rdata   (rdata),
        .ctrl_rresp   (rresp)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called and returns on a falling edge; AR handshake happens on the next rising edge.
    task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        arvalid = 1'b1;
        araddr  = a;
        @(posedge aclk);
        @(negedge aclk);
        arvalid = 1'b0;
        chk($sformatf("rvalid_after_ar_%h", a), 32'(rvalid), 32'd1);
        d      = rdata;
        r      = rresp;
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r);
        awvalid = 1'b1;
        wvalid  = 1'b1;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        #1;
        chk($sformatf("awready_wready_%h", a), 32'({awready, wready}), 32'd3);
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk($sformatf("bvalid_after_w_%h", a), 32'(bvalid), 32'd1);
        r      = bresp;
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    logic [31:0] d, u1, u2;
    logic [1:0]  r;

    initial begin
        areset  = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0;
        awaddr  = '0;   araddr = '0;   wdata  = '0;  wstrb = '0;
        repeat (3) @(negedge aclk);

        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        chk("rst_rresp",   32'(rresp),   32'd0);
        chk("rst_bresp",   32'(bresp),   32'd0);
        areset = 1'b0;

        // Uptime across the wrap: the reset value is 64 cycles below 2^32.
        do_read(8'h0C, u1, r);
        chk("uptime_at_reset", u1, UP_RST);
        repeat (98) @(negedge aclk);
        do_read(8'h0C, u2, r);
        chk("uptime_wrap_diff", u2 - u1, 32'd100);
        chk("uptime_wrap_val",  u2,      32'h0000_0024);

        do_read(8'h00, d, r); chk("magic", d, 32'h4944_4E54); chk("magic_resp", 32'(r), 32'd0);
        do_read(8'h04, d, r); chk("version", d, 32'h0203_0004); chk("version_resp", 32'(r), 32'd0);
        do_read(8'h08, d, r); chk("build_id", d, 32'h1234_5678);
        do_read(8'h14, d, r); chk("name_words", d, 32'd4);
        do_read(8'h40, d, r); chk("name0", d, 32'h0); chk("name0_resp", 32'(r), 32'd0);
        do_read(8'h44, d, r); chk("name1", d, 32'h0);
        do_read(8'h4C, d, r); chk("name3", d, 32'h5445_5354);
        do_read(8'h4F, d, r); chk("name3_lowbits", d, 32'h5445_5354);
        do_read(8'h50, d, r); chk("unmapped50", d, 32'h0); chk("unmapped50_resp", 32'(r), 32'd2);
        do_read(8'h18, d, r); chk("unmapped18", d, 32'h0); chk("unmapped18_resp", 32'(r), 32'd2);

        do_read(8'h10, d, r); chk("scratch_init", d, 32'h0);
        do_write(8'h10, 32'hDEAD_BEEF, 4'b0101, r); chk("scratch_bresp", 32'(r), 32'd0);
        do_read(8'h10, d, r); chk("scratch_strb", d, 32'h00AD_00EF);
        do_write(8'h04, 32'hFFFF_FFFF, 4'b1111, r); chk("ro_bresp", 32'(r), 32'd2);
        do_read(8'h04, d, r); chk("version_kept", d, 32'h0203_0004);
        do_read(8'h10, d, r); chk("scratch_kept_ro", d, 32'h00AD_00EF);

        // Read response held while rready stays low.
        arvalid = 1'b1;
        araddr  = 8'h00;
        @(posedge aclk);
        @(negedge aclk);
        arvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("hold_rvalid",  32'(rvalid),  32'd1);
            chk("hold_rdata",   rdata,        32'h4944_4E54);
            chk("hold_arready", 32'(arready), 32'd0);
            @(negedge aclk);
        end
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        chk("release_rvalid",  32'(rvalid),  32'd0);
        chk("release_arready", 32'(arready), 32'd1);

        // Address without data must not be accepted.
        awvalid = 1'b1;
        awaddr  = 8'h10;
        wdata   = 32'h5555_5555;
        wstrb   = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("aw_alone_awready", 32'({awready, wready}), 32'd0);
            @(negedge aclk);
        end
        chk("aw_alone_bvalid", 32'(bvalid), 32'd0);
        awvalid = 1'b0;
        do_read(8'h10, d, r); chk("scratch_after_aw_alone", d, 32'h00AD_00EF);

        do_read(8'h0C, u1, r);
        repeat (98) @(negedge aclk);
        do_read(8'h0C, u2, r);
        chk("uptime_diff", u2 - u1, 32'd100);

        // Concurrent read and write of scratch, then reset with both responses pending.
        arvalid = 1'b1; araddr = 8'h10;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 8'h10; wdata = 32'h1122_3344; wstrb = 4'b1111;
        #1;
        chk("conc_awready", 32'(awready), 32'd1);
        @(posedge aclk);
        @(negedge aclk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("conc_rvalid", 32'(rvalid), 32'd1);
        chk("conc_rdata_prewrite", rdata, 32'h00AD_00EF);
        chk("conc_bvalid", 32'(bvalid), 32'd1);
        chk("conc_bresp", 32'(bresp), 32'd0);
        areset = 1'b1;
        @(negedge aclk);
        chk("midrst_rvalid",  32'(rvalid),  32'd0);
        chk("midrst_bvalid",  32'(bvalid),  32'd0);
        chk("midrst_arready", 32'(arready), 32'd1);
        chk("midrst_rdata",   rdata,        32'd0);
        areset = 1'b0;
        do_read(8'h10, d, r); chk("scratch_after_reset", d, 32'h0);

        do_write(8'h10, 32'hAABB_CCDD, 4'b1010, r); chk("scratch2_bresp", 32'(r), 32'd0);
        do_read(8'h10, d, r); chk("scratch_strb1010", d, 32'hAA00_CC00);
        do_write(8'h10, 32'h1234_5678, 4'b0001, r);
        do_read(8'h10, d, r); chk("scratch_strb0001", d, 32'hAA00_CC78);
        do_write(8'h50, 32'hFFFF_FFFF, 4'b1111, r); chk("unmapped_bresp", 32'(r), 32'd2);
        do_read(8'h10, d, r); chk("scratch_kept_unmapped", d, 32'hAA00_CC78);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
